sparse_config_sequencer: RTL and testbench
==========================================

SPARSE_CONFIG_SEQUENCER -- requirements
Module: sparse_config_sequencer

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 16: cycles flush is held with stall asserted.
REQ-002 SHALL have parameter RELEASE_CYCLES, default 2: cycles flush is held after stall drops.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 20000: RUN-state cycle limit.
REQ-004 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: single-cycle request to begin a configure/run sequence.
REQ-007 SHALL have port bs_valid, input, 1: bitstream word valid.
REQ-008 SHALL have port bs_data, input, 64: bitstream word; [63:32] config address, [31:0] config data.
REQ-009 SHALL have port bs_last, input, 1: marks the final bitstream word; qualified by the handshake.
REQ-010 SHALL have port bs_ready, output, 1: sequencer accepts a bitstream word.
REQ-011 SHALL have port config_config_addr, output, 32: registered config address.
REQ-012 SHALL have port config_config_data, output, 32: registered config data.
REQ-013 SHALL have port config_write, output, 1: config write strobe.
REQ-014 SHALL have port config_read, output, 1: constant 0.
REQ-015 SHALL have port stall, output, 1: array stall.
REQ-016 SHALL have port flush, output, 1: array flush.
REQ-017 SHALL have port array_done, input, 1: completion from the array.
REQ-018 SHALL have port cycle_count, output, 64: RUN cycles elapsed.
REQ-019 SHALL have port word_count, output, 16: bitstream words written, saturating at 16'hFFFF.
REQ-020 SHALL have port busy, output, 1: sequencer is in CONFIG, FLUSH, RELEASE or RUN.
REQ-021 SHALL have port done, output, 1: sequence completed normally.
REQ-022 SHALL have port timed_out, output, 1: RUN exceeded TIMEOUT_CYCLES.

Function
REQ-023 SHALL implement states IDLE, CONFIG, FLUSH, RELEASE, RUN, DONE and TIMEOUT.
REQ-024 SHALL accept start only in IDLE, DONE or TIMEOUT; there it clears cycle_count, word_count, done and timed_out and enters CONFIG on the next cycle; start in any other state SHALL be ignored.
REQ-025 SHALL drive bs_ready=1 only in CONFIG.
REQ-026 SHALL, on handshake (bs_valid and bs_ready) in cycle t, present addr/data with config_write=1 in cycle t+1 only.
REQ-027 SHALL support back-to-back handshakes: one word per cycle, no bubble inserted.
REQ-028 SHALL increment word_count on each handshake, saturating at 16'hFFFF.
REQ-029 SHALL, on a handshake with bs_last=1, enter FLUSH on the next cycle; the last word's config_write occurs in that first FLUSH cycle.
REQ-030 SHALL hold stall=1 in IDLE, CONFIG, FLUSH, DONE and TIMEOUT.
REQ-031 SHALL, in FLUSH, drive flush=1 and stall=1 for exactly FLUSH_CYCLES cycles, then enter RELEASE.
REQ-032 SHALL, in RELEASE, drive flush=1 and stall=0 for exactly RELEASE_CYCLES cycles, then enter RUN.
REQ-033 SHALL, in RUN, drive flush=0 and stall=0, and increment cycle_count by 1 every RUN cycle, starting at 0.
REQ-034 SHALL, on array_done=1 in RUN, enter DONE next cycle with done=1 and cycle_count frozen.
REQ-035 SHALL, when cycle_count reaches TIMEOUT_CYCLES without array_done, enter TIMEOUT with timed_out=1 and cycle_count frozen.
REQ-036 SHALL give array_done priority over timeout when both occur in the same cycle.
REQ-037 SHALL ignore array_done outside RUN.
REQ-038 SHALL hold done and timed_out until the next accepted start or reset.
REQ-039 SHALL ignore bs_valid and bs_data outside CONFIG and change no state because of them.
REQ-040 SHALL drive busy=1 exactly in CONFIG, FLUSH, RELEASE and RUN.

Reset
REQ-041 SHALL, on reset (including mid-operation), enter IDLE on the next edge with: stall=1, flush=0, config_write=0, bs_ready=0, addr/data=0, cycle_count=0, word_count=0, done=0, timed_out=0, busy=0.
REQ-042 SHALL give reset priority over start and every other input.

Verification
REQ-043 SHALL cover: 3-word back-to-back stream (0x1/0xA, 0x2/0xB, 0x3/0xC with last) -> three consecutive config_write pulses with matching addr/data, word_count=3.
REQ-044 SHALL cover: default parameters -> flush high 18 cycles, stall low starting at flush cycle 17; array_done after 100 RUN cycles -> done=1, cycle_count=100.
REQ-045 SHALL cover: TIMEOUT_CYCLES=50 with array_done never asserted -> timed_out=1, cycle_count=50, stall=1.
REQ-046 SHALL cover: array_done coincident with the timeout cycle -> done=1, timed_out=0.
REQ-047 SHALL cover: bs_valid toggling randomly, plus start pulsed during CONFIG -> writes match accepted words only; start ignored.
REQ-048 SHALL cover: reset asserted in FLUSH and in RUN -> reset values next cycle; a following start reruns the full sequence correctly.

Source files
------------

// File: rtl/sparse_config_sequencer.sv
// Configuration sequencer: streams bitstream words into config writes, then runs
// a flush/release preamble and a timed RUN phase until the array reports done.
module sparse_config_sequencer #(
    parameter int unsigned FLUSH_CYCLES   = 16,
    parameter int unsigned RELEASE_CYCLES = 2,
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        bs_valid,
    input  logic [63:0] bs_data,
    input  logic        bs_last,
    output logic        bs_ready,
    output logic [31:0] config_config_addr,
    output logic [31:0] config_config_data,
    output logic        config_write,
    output logic        config_read,
    output logic        stall,
    output logic        flush,
    input  logic        array_done,
    output logic [63:0] cycle_count,
    output logic [15:0] word_count,
    output logic        busy,
    output logic        done,
    output logic        timed_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONFIG,
        S_FLUSH,
        S_RELEASE,
        S_RUN,
        S_DONE,
        S_TIMEOUT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] phase_q, phase_d;
    logic [63:0] cycle_q, cycle_d;
    logic [15:0] words_q, words_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        write_q, write_d;
    logic        handshake;

    // bs_ready is only ever high in CONFIG, so the state test is the handshake qualifier.
    assign handshake = bs_valid && (state_q == S_CONFIG);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            cycle_q <= '0;
            words_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cycle_q <= cycle_d;
            words_q <= words_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            write_q <= write_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cycle_d   = cycle_q;
        words_d   = words_q;
        addr_d    = addr_q;
        data_d    = data_q;
        write_d   = 1'b0;
        bs_ready  = 1'b0;
        stall     = 1'b1;
        flush     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        timed_out = 1'b0;

        if (handshake) begin
            addr_d  = bs_data[63:32];
            data_d  = bs_data[31:0];
            write_d = 1'b1;
            if (words_q != '1) begin
                words_d = words_q + 16'd1;
            end
        end

        case (state_q)
            S_IDLE, S_DONE, S_TIMEOUT: begin
                done      = (state_q == S_DONE);
                timed_out = (state_q == S_TIMEOUT);
                if (start) begin
                    state_d = S_CONFIG;
                    cycle_d = '0;
                    words_d = '0;
                end
            end
            S_CONFIG: begin
                bs_ready = 1'b1;
                busy     = 1'b1;
                if (bs_valid && bs_last) begin
                    state_d = S_FLUSH;
                    phase_d = '0;
                end
            end
            S_FLUSH: begin
                flush = 1'b1;
                busy  = 1'b1;
                if (phase_q == FLUSH_CYCLES - 32'd1) begin
                    state_d = S_RELEASE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 32'd1;
                end
            end
            S_RELEASE: begin
                flush = 1'b1;
                stall = 1'b0;
                busy  = 1'b1;
                if (phase_q == RELEASE_CYCLES - 32'd1) begin
                    state_d = S_RUN;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 32'd1;
                end
            end
            S_RUN: begin
                stall = 1'b0;
                busy  = 1'b1;
                // The current cycle is counted before deciding, so the final value equals RUN cycles spent.
                cycle_d = cycle_q + 64'd1;
                if (array_done) begin
                    state_d = S_DONE;
                end else if (cycle_d == 64'(TIMEOUT_CYCLES)) begin
                    state_d = S_TIMEOUT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign config_config_addr = addr_q;
    assign config_config_data = data_q;
    assign config_write       = write_q;
    assign config_read        = 1'b0;
    assign cycle_count        = cycle_q;
    assign word_count         = words_q;

endmodule

// File: tb/tb_sparse_config_sequencer.sv
// Bench for sparse_config_sequencer: a default instance and a short-timeout instance
// share one stimulus stream and are checked against a phase-arithmetic model.
module tb_sparse_config_sequencer;

    localparam int F  = 16;
    localparam int R  = 2;
    localparam int P  = F + R;
    localparam int TO = 50;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        bs_valid = 1'b0;
    logic [63:0] bs_data = '0;
    logic        bs_last = 1'b0;
    logic        array_done = 1'b0;

    logic        d_ready, d_write, d_read, d_stall, d_flush, d_busy, d_done, d_tout;
    logic [31:0] d_addr, d_data;
    logic [63:0] d_cycles;
    logic [15:0] d_words;
    logic        t_ready, t_write, t_read, t_stall, t_flush, t_busy, t_done, t_tout;
    logic [31:0] t_addr, t_data;
    logic [63:0] t_cycles;
    logic [15:0] t_words;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sparse_config_sequencer dut (
        .clk(clk), .reset(reset), .start(start),
        .bs_valid(bs_valid), .bs_data(bs_data), .bs_last(bs_last), .bs_ready(d_ready),
        .config_config_addr(d_addr), .config_config_data(d_data),
        .config_write(d_write), .config_read(d_read),
        .stall(d_stall), .flush(d_flush), .array_done(array_done),
        .cycle_count(d_cycles), .word_count(d_words),
        .busy(d_busy), .done(d_done), .timed_out(d_tout)
    );

    sparse_config_sequencer #(.TIMEOUT_CYCLES(TO)) tdut (
        .clk(clk), .reset(reset), .start(start),
        .bs_valid(bs_valid), .bs_data(bs_data), .bs_last(bs_last), .bs_ready(t_ready),
        .config_config_addr(t_addr), .config_config_data(t_data),
        .config_write(t_write), .config_read(t_read),
        .stall(t_stall), .flush(t_flush), .array_done(array_done),
        .cycle_count(t_cycles), .word_count(t_words),
        .busy(t_busy), .done(t_done), .timed_out(t_tout)
    );

    typedef struct {
        logic        in_rst, in_start, in_valid, in_last, in_adone;
        logic [63:0] in_data;
        logic        e_ready, e_write, e_stall, e_flush, e_busy;
        logic [31:0] e_addr, e_data;
        logic [15:0] e_words;
    } vec_t;

    vec_t tbl[8];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chkw(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    task automatic chkb2(input string nm, input logic dv, input logic tv, input logic ev);
        chkb({"d.", nm}, dv, ev);
        chkb({"t.", nm}, tv, ev);
    endtask

    task automatic chkw2(input string nm, input logic [63:0] dv, input logic [63:0] tv,
                         input logic [63:0] ev);
        chkw({"d.", nm}, dv, ev);
        chkw({"t.", nm}, tv, ev);
    endtask

    task automatic check_idle(input string tag);
        chkb2({tag, ".ready"}, d_ready, t_ready, 1'b0);
        chkb2({tag, ".write"}, d_write, t_write, 1'b0);
        chkb2({tag, ".read"},  d_read,  t_read,  1'b0);
        chkb2({tag, ".stall"}, d_stall, t_stall, 1'b1);
        chkb2({tag, ".flush"}, d_flush, t_flush, 1'b0);
        chkb2({tag, ".busy"},  d_busy,  t_busy,  1'b0);
        chkb2({tag, ".done"},  d_done,  t_done,  1'b0);
        chkb2({tag, ".tout"},  d_tout,  t_tout,  1'b0);
        chkw2({tag, ".addr"},  64'(d_addr), 64'(t_addr), 64'd0);
        chkw2({tag, ".data"},  64'(d_data), 64'(t_data), 64'd0);
        chkw2({tag, ".cycles"}, d_cycles, t_cycles, 64'd0);
        chkw2({tag, ".words"}, 64'(d_words), 64'(t_words), 64'd0);
    endtask

    // One full start/stream/flush/run sequence. n words, array_done in RUN cycle d,
    // rnd adds random valid gaps and ignored inputs, rst_k>0 resets at phase sample k.
    task automatic run_seq(input int n, input int d, input bit rnd, input int rst_k);
        int acc = 0;
        int guard = 0;
        int k = 1;
        int j;
        int fl_cnt = 0;
        int low_k = 0;
        bit cfg = 1'b1;
        bit pend = 1'b0;
        logic [63:0] w;
        logic [63:0] last_w = '0;

        start = 1'b1; bs_valid = 1'b0; bs_last = 1'b0; array_done = 1'b0;
        tick;
        start = 1'b0;
        chkb2("st.busy", d_busy, t_busy, 1'b1);
        chkb2("st.done", d_done, t_done, 1'b0);
        chkb2("st.tout", d_tout, t_tout, 1'b0);
        chkw2("st.cycles", d_cycles, t_cycles, 64'd0);

        forever begin
            chkb2("cfg.write", d_write, t_write, pend);
            if (pend) begin
                chkw2("cfg.addr", 64'(d_addr), 64'(t_addr), 64'(last_w[63:32]));
                chkw2("cfg.data", 64'(d_data), 64'(t_data), 64'(last_w[31:0]));
            end
            chkb2("cfg.ready", d_ready, t_ready, cfg);
            chkw2("cfg.words", 64'(d_words), 64'(t_words), 64'(acc));
            if (!cfg) break;
            if (guard > 400) begin
                vectors++; miscompares++;
                $display("FAIL cfg_budget: got %0d words, expected %0d", acc, n);
                return;
            end
            guard++;
            bs_valid   = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            w          = rnd ? {$urandom, $urandom} : {32'(acc + 1), 32'(acc + 10)};
            bs_data    = w;
            bs_last    = (acc == n - 1);
            start      = rnd && ($urandom_range(0, 3) == 0);
            array_done = rnd && ($urandom_range(0, 3) == 0);
            pend = bs_valid;
            if (bs_valid) begin
                last_w = w;
                acc++;
                if (acc == n) cfg = 1'b0;
            end
            tick;
        end

        forever begin
            j = k - P;
            if (k > 1) chkb2("ph.write", d_write, t_write, 1'b0);
            chkb2("ph.ready", d_ready, t_ready, 1'b0);
            chkw2("ph.words", 64'(d_words), 64'(t_words), 64'(n));
            if (d_flush) fl_cnt++;
            if (!d_stall && low_k == 0) low_k = k;
            if (j < 1) begin
                chkb2("ph.flush", d_flush, t_flush, 1'b1);
                chkb2("ph.stall", d_stall, t_stall, k <= F);
                chkb2("ph.busy", d_busy, t_busy, 1'b1);
                chkw2("ph.cycles", d_cycles, t_cycles, 64'd0);
            end else begin
                chkb("d.run.flush", d_flush, 1'b0);
                chkb("d.run.stall", d_stall, 1'b0);
                chkb("d.run.busy", d_busy, 1'b1);
                chkw("d.run.cycles", d_cycles, 64'(j - 1));
                if (j <= TO) begin
                    chkb("t.run.stall", t_stall, 1'b0);
                    chkb("t.run.tout", t_tout, 1'b0);
                    chkw("t.run.cycles", t_cycles, 64'(j - 1));
                end else begin
                    chkb("t.to.tout", t_tout, 1'b1);
                    chkb("t.to.stall", t_stall, 1'b1);
                    chkb("t.to.busy", t_busy, 1'b0);
                    chkw("t.to.cycles", t_cycles, 64'(TO));
                end
            end
            if (rst_k == k) begin
                reset = 1'b1; start = 1'b1; bs_valid = 1'b1; bs_last = 1'b1; array_done = 1'b1;
                tick;
                reset = 1'b0; start = 1'b0; bs_valid = 1'b0; bs_last = 1'b0; array_done = 1'b0;
                check_idle("rst");
                return;
            end
            bs_valid   = rnd && ($urandom_range(0, 1) == 1);
            bs_data    = {$urandom, $urandom};
            start      = rnd && (k <= P) && ($urandom_range(0, 3) == 0);
            array_done = (j == d) || (rnd && (k <= P) && ($urandom_range(0, 2) == 0));
            tick;
            if (j == d) break;
            k++;
        end
        array_done = 1'b0; start = 1'b0; bs_valid = 1'b0;

        chkw("d.flush_len", 64'(fl_cnt), 64'(P));
        chkw("d.stall_low_k", 64'(low_k), 64'(F + 1));
        chkb("d.end.done", d_done, 1'b1);
        chkb("d.end.tout", d_tout, 1'b0);
        chkw("d.end.cycles", d_cycles, 64'(d));
        chkb2("end.busy", d_busy, t_busy, 1'b0);
        chkb2("end.stall", d_stall, t_stall, 1'b1);
        chkb2("end.flush", d_flush, t_flush, 1'b0);
        chkb("t.end.done", t_done, d <= TO);
        chkb("t.end.tout", t_tout, d > TO);
        chkw("t.end.cycles", t_cycles, 64'((d <= TO) ? d : TO));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,
                   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 16'd0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 64'h0000_0005_0000_0005,
                   1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 16'd0};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h0000_0009_0000_0009,
                   1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 16'd0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0000_0001_0000_000A,
                   1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1, 32'hA, 16'd1};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0000_0002_0000_000B,
                   1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h2, 32'hB, 16'd2};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0000_0003_0000_000C,
                   1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h3, 32'hC, 16'd3};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0000_0007_0000_0007,
                   1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h3, 32'hC, 16'd3};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,
                   1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h3, 32'hC, 16'd3};

        for (int i = 0; i < 8; i++) begin
            reset      = tbl[i].in_rst;
            start      = tbl[i].in_start;
            bs_valid   = tbl[i].in_valid;
            bs_last    = tbl[i].in_last;
            array_done = tbl[i].in_adone;
            bs_data    = tbl[i].in_data;
            tick;
            chkb2($sformatf("vec%0d.ready", i), d_ready, t_ready, tbl[i].e_ready);
            chkb2($sformatf("vec%0d.write", i), d_write, t_write, tbl[i].e_write);
            chkb2($sformatf("vec%0d.stall", i), d_stall, t_stall, tbl[i].e_stall);
            chkb2($sformatf("vec%0d.flush", i), d_flush, t_flush, tbl[i].e_flush);
            chkb2($sformatf("vec%0d.busy", i),  d_busy,  t_busy,  tbl[i].e_busy);
            chkw2($sformatf("vec%0d.addr", i), 64'(d_addr), 64'(t_addr), 64'(tbl[i].e_addr));
            chkw2($sformatf("vec%0d.data", i), 64'(d_data), 64'(t_data), 64'(tbl[i].e_data));
            chkw2($sformatf("vec%0d.words", i), 64'(d_words), 64'(t_words), 64'(tbl[i].e_words));
        end

        // Reset while flushing, with start asserted alongside.
        reset = 1'b1; start = 1'b1; bs_valid = 1'b0; bs_last = 1'b0; array_done = 1'b0;
        tick;
        reset = 1'b0; start = 1'b0;
        check_idle("rst_flush");

        run_seq(3, 100, 1'b0, 0);

        for (int i = 0; i < 4; i++) begin
            array_done = 1'b1; bs_valid = 1'b1; bs_last = 1'b1;
            tick;
            chkb("hold.d.done", d_done, 1'b1);
            chkw("hold.d.cycles", d_cycles, 64'd100);
            chkb("hold.t.tout", t_tout, 1'b1);
            chkw("hold.t.cycles", t_cycles, 64'(TO));
            chkw2("hold.words", 64'(d_words), 64'(t_words), 64'd3);
        end
        array_done = 1'b0; bs_valid = 1'b0; bs_last = 1'b0;

        run_seq(3, TO, 1'b0, 0);
        run_seq(2, 200, 1'b1, P + 10);
        run_seq(3, 30, 1'b0, 0);
        run_seq(4, 200, 1'b0, 6);
        run_seq(1, 1, 1'b0, 0);

        for (int i = 0; i < 16; i++) begin
            run_seq($urandom_range(1, 8), $urandom_range(1, 70), 1'b1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
